// File: rtl/neureka_job_dispatcher.sv
// neureka_job_dispatcher: periph-bus initiator that acquires a NEUREKA context,
// writes the job registers and TRIGGER, then waits for the end-of-job event.
// One job and at most one bus transaction in flight at any time.
module neureka_job_dispatcher #(
  parameter int unsigned   N_REG         = 24,
  parameter int unsigned   AW            = 32,
  parameter int unsigned   DW            = 32,
  parameter int unsigned   ID            = 8,
  parameter logic [AW-1:0] BASE_ADDR     = '0,
  parameter logic [AW-1:0] JOB_OFFS      = 'h20,
  parameter int unsigned   RETRY_WAIT    = 4,
  parameter int unsigned   REGFILE_N_EVT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [N_REG*DW-1:0]      job_data_i,
  output logic                     req_o,
  input  logic                     gnt_i,
  output logic [AW-1:0]            add_o,
  output logic                     wen_o,
  output logic [DW/8-1:0]          be_o,
  output logic [DW-1:0]            data_o,
  output logic [ID-1:0]            id_o,
  input  logic                     r_valid_i,
  input  logic [DW-1:0]            r_data_i,
  input  logic [ID-1:0]            r_id_i,
  input  logic [REGFILE_N_EVT-1:0] evt_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [7:0]               done_id_o
);
  localparam int KW = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int BW = $clog2(RETRY_WAIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ACQ, S_BACKOFF, S_CFG, S_TRIG, S_WAIT} state_t;
  state_t r_state, w_next;

  logic [N_REG*DW-1:0] r_desc;
  logic                r_req, r_wen, r_wait, r_clr_pend, r_evt, r_done, r_init;
  logic [AW-1:0]       r_add;
  logic [DW-1:0]       r_data;
  logic [ID-1:0]       r_id, r_exp_id;
  logic [KW-1:0]       r_k;
  logic [BW-1:0]       r_bo_cnt;
  logic [7:0]          r_done_id;

  logic          w_hs, w_rsp, w_bus_idle, w_abort, w_bo_done, w_issue, w_evt, w_last;
  logic [ID-1:0] w_exp_id;
  logic [AW-1:0] w_iss_add;
  logic          w_iss_wen;
  logic [DW-1:0] w_iss_data;
  logic          w_unused;

  assign w_hs       = job_valid_i & job_ready_o;
  // While the request is still up the response can only belong to it (zero-latency
  // response); after gnt it must carry the ID captured at grant time.
  assign w_exp_id   = r_req ? r_id : r_exp_id;
  assign w_rsp      = r_valid_i & (r_id_i == w_exp_id) & (r_wait | (r_req & gnt_i));
  assign w_bus_idle = ~r_req & ~r_wait;
  assign w_abort    = r_clr_pend & w_bus_idle;
  assign w_bo_done  = (r_state == S_BACKOFF) && (r_bo_cnt == BW'(RETRY_WAIT));
  assign w_evt      = r_evt | evt_i[0];
  assign w_last     = (r_k == KW'(N_REG - 1));
  // The retry read is launched from the last backoff cycle so the bus sees exactly
  // RETRY_WAIT idle cycles between the refused response and the next request.
  assign w_issue    = w_bus_idle & ~r_clr_pend & ~clear_i &
                      ((r_state == S_ACQ) || (r_state == S_CFG) || (r_state == S_TRIG) || w_bo_done);
  assign w_unused   = ^{evt_i, r_data_i};

  assign job_ready_o = (r_state == S_IDLE) & r_init & ~clear_i;
  assign busy_o      = (r_state != S_IDLE);
  assign req_o       = r_req;
  assign add_o       = r_add;
  assign wen_o       = r_wen;
  assign be_o        = '1;
  assign data_o      = r_data;
  assign id_o        = r_id;
  assign done_o      = r_done;
  assign done_id_o   = r_done_id;

  // Address/data of the transaction the current state wants to launch
  always_comb begin
    w_iss_add  = BASE_ADDR + JOB_OFFS + AW'(4);
    w_iss_wen  = 1'b1;
    w_iss_data = '0;
    case (r_state)
      S_CFG: begin
        w_iss_add  = BASE_ADDR + JOB_OFFS + AW'({r_k, 2'b00});
        w_iss_wen  = 1'b0;
        w_iss_data = r_desc[r_k*DW +: DW];
      end
      S_TRIG: begin
        w_iss_add  = BASE_ADDR + JOB_OFFS;
        w_iss_wen  = 1'b0;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a pending clear wins once the bus is quiet
  always_comb begin
    w_next = r_state;
    if (w_abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_hs) w_next = S_ACQ;
        S_ACQ:     if (w_rsp) w_next = r_data_i[DW-1] ? S_BACKOFF : S_CFG;
        S_BACKOFF: if (w_bo_done) w_next = S_ACQ;
        S_CFG:     if (w_rsp && w_last) w_next = S_TRIG;
        S_TRIG:    if (w_rsp) w_next = S_WAIT;
        S_WAIT:    if (w_evt) w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Bus initiator, job counters, clear/event capture and completion outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_init     <= 1'b0;
      r_desc     <= '0;
      r_req      <= 1'b0;
      r_add      <= '0;
      r_wen      <= 1'b1;
      r_data     <= '0;
      r_id       <= '0;
      r_exp_id   <= '0;
      r_wait     <= 1'b0;
      r_clr_pend <= 1'b0;
      r_evt      <= 1'b0;
      r_done     <= 1'b0;
      r_done_id  <= '0;
      r_k        <= '0;
      r_bo_cnt   <= '0;
    end else begin
      r_init <= 1'b1;
      r_done <= (r_state == S_WAIT) && w_evt && !r_clr_pend;
      if (w_hs) r_desc <= job_data_i;

      if (w_issue) begin
        r_req  <= 1'b1;
        r_add  <= w_iss_add;
        r_wen  <= w_iss_wen;
        r_data <= w_iss_data;
      end else if (r_req && gnt_i) begin
        r_req    <= 1'b0;
        r_id     <= r_id + 1'b1;
        r_exp_id <= r_id;
      end

      if (r_req && gnt_i) r_wait <= ~w_rsp;
      else if (w_rsp)     r_wait <= 1'b0;

      if (w_abort)                             r_clr_pend <= 1'b0;
      else if (clear_i && r_state != S_IDLE)   r_clr_pend <= 1'b1;

      // Sticky end-of-job flag, armed only once TRIGGER has been granted
      if ((r_state == S_WAIT) || (r_state == S_TRIG && r_wait)) begin
        if (evt_i[0]) r_evt <= 1'b1;
      end else begin
        r_evt <= 1'b0;
      end

      if (r_state == S_ACQ && w_rsp) begin
        if (r_data_i[DW-1]) begin
          r_bo_cnt <= BW'(1);
        end else begin
          r_done_id <= r_data_i[7:0];
          r_k       <= '0;
        end
      end
      if (r_state == S_BACKOFF)            r_bo_cnt <= r_bo_cnt + 1'b1;
      if (r_state == S_CFG && w_rsp && !w_last) r_k <= r_k + 1'b1;
    end
  end
endmodule

// File: tb/tb_neureka_job_dispatcher.sv
// Directed bench for neureka_job_dispatcher: a behavioural periph slave with
// configurable grant stall / response latency plus a transaction log, and a
// sequence of jobs checked against hand-derived address/data/timing values.
module tb_neureka_job_dispatcher;
  localparam int N_REG = 24, AW = 32, DW = 32, ID = 8, NEV = 2, LOGN = 512;

  logic clk_i, rst_i, clear_i, job_valid_i, job_ready_o;
  logic [N_REG*DW-1:0] job_data_i;
  logic req_o, gnt_i, wen_o, r_valid_i, busy_o, done_o;
  logic [AW-1:0] add_o;
  logic [DW/8-1:0] be_o;
  logic [DW-1:0] data_o, r_data_i;
  logic [ID-1:0] id_o, r_id_i;
  logic [NEV-1:0] evt_i;
  logic [7:0] done_id_o;

  neureka_job_dispatcher #(.N_REG(N_REG), .AW(AW), .DW(DW), .ID(ID), .BASE_ADDR('0),
    .JOB_OFFS('h20), .RETRY_WAIT(4), .REGFILE_N_EVT(NEV)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .job_valid_i(job_valid_i),
    .job_ready_o(job_ready_o), .job_data_i(job_data_i), .req_o(req_o), .gnt_i(gnt_i),
    .add_o(add_o), .wen_o(wen_o), .be_o(be_o), .data_o(data_o), .id_o(id_o),
    .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_id_i(r_id_i), .evt_i(evt_i),
    .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o));

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0;
  logic [7:0] last_done_id;

  // test-owned slave configuration
  int cfg_smin, cfg_smax, cfg_lmin, cfg_lmax, evt_cmd, acq_base;
  bit evt_on_trig;
  logic [31:0] acq_tab [8];
  // slave-owned state and log
  int evt_done = 0, acq_cnt = 0, log_n = 0;
  logic [31:0] log_add [LOGN];
  logic [31:0] log_data [LOGN];
  logic        log_wen [LOGN];
  int          log_req_cyc [LOGN];
  int          log_rsp_cyc [LOGN];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end
  initial forever begin @(posedge clk_i); cyc++; end
  initial forever begin
    @(negedge clk_i);
    if (done_o) begin done_cnt++; last_done_id = done_id_o; end
  end
  initial begin
    #1ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // Periph slave: grants after a random stall, answers after a random latency,
  // and checks request stability, ID sequence and single-outstanding behaviour.
  initial begin
    int s_seen, s_pend, s_lat, s_stall, s_idx, s_wr, s_req_cyc, outst, ai;
    logic [31:0] s_add, s_data, s_rdata;
    logic s_wen, s_trig;
    logic [7:0] s_id, s_exp_id;
    s_seen = 0; s_pend = 0; s_lat = 0; s_stall = 0; s_idx = 0; s_wr = 0; s_req_cyc = 0;
    s_exp_id = '0; s_trig = 0; s_add = '0; s_data = '0; s_rdata = '0; s_wen = 0; s_id = '0;
    gnt_i = 0; r_valid_i = 0; r_id_i = '0; r_data_i = '0; evt_i = '0;
    forever begin
      @(negedge clk_i);
      gnt_i = 0; r_valid_i = 0; evt_i = '0;
      if (rst_i) begin
        s_seen = 0; s_pend = 0; s_exp_id = '0; s_wr = 0;
      end else begin
        outst = s_pend;
        if (evt_cmd != evt_done) begin evt_i[0] = 1'b1; evt_done = evt_cmd; end
        if (s_pend != 0) begin
          if (s_lat == 0) begin
            r_valid_i = 1; r_id_i = s_id; r_data_i = s_rdata; s_pend = 0;
            if (s_idx < LOGN) log_rsp_cyc[s_idx] = cyc;
            if (evt_on_trig && s_trig) evt_i[0] = 1'b1;
          end else s_lat--;
        end
        if (s_seen != 0 && !req_o) begin chk("req_held_until_gnt", 0, 1); s_seen = 0; end
        if (req_o) begin
          if (s_seen == 0) begin
            chk("single_outstanding", outst, 0);
            chk("id_seq", id_o, s_exp_id);
            s_seen = 1; s_add = add_o; s_wen = wen_o; s_data = data_o; s_id = id_o;
            s_req_cyc = cyc;
            s_stall = $urandom_range(cfg_smax, cfg_smin);
          end else begin
            chk("add_stable", add_o, s_add);
            chk("wen_stable", wen_o, s_wen);
            chk("data_stable", data_o, s_data);
            chk("id_stable", id_o, s_id);
          end
          if (s_stall == 0) begin
            gnt_i = 1; s_seen = 0; s_exp_id++;
            s_idx = log_n;
            if (log_n < LOGN) begin
              log_add[log_n] = s_add; log_wen[log_n] = s_wen; log_data[log_n] = s_data;
              log_req_cyc[log_n] = s_req_cyc; log_rsp_cyc[log_n] = -1;
            end
            log_n++;
            if (s_wen) begin
              ai = acq_cnt - acq_base;
              s_rdata = (ai >= 0 && ai < 8) ? acq_tab[ai] : 32'h0;
              acq_cnt++; s_wr = 0; s_trig = 0;
            end else begin
              s_rdata = '0; s_trig = (s_wr == N_REG); s_wr++;
            end
            s_lat = $urandom_range(cfg_lmax, cfg_lmin);
            if (s_lat == 0) begin
              r_valid_i = 1; r_id_i = s_id; r_data_i = s_rdata;
              if (s_idx < LOGN) log_rsp_cyc[s_idx] = cyc;
              if (evt_on_trig && s_trig) evt_i[0] = 1'b1;
            end else begin
              s_pend = 1; s_lat--;
            end
          end else s_stall--;
        end
      end
    end
  end

  function automatic logic [31:0] word(input int seed, input int k);
    return {seed[7:0], k[7:0], 16'hC0DE ^ 16'(k * 37)};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk_i); #1; end
  endtask

  task automatic set_bus(input int smin, input int smax, input int lmin, input int lmax);
    cfg_smin = smin; cfg_smax = smax; cfg_lmin = lmin; cfg_lmax = lmax;
  endtask

  task automatic wait_log(input int n, input string tag);
    int t = 0;
    while (log_n < n && t < 2000) begin tick(1); t++; end
    if (log_n < n) chk(tag, log_n, n);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int t = 0;
    while (done_cnt <= d0 && t < 50) begin tick(1); t++; end
    if (done_cnt <= d0) chk(tag, done_cnt - d0, 1);
  endtask

  task automatic send_job(input int seed);
    int t = 0;
    for (int k = 0; k < N_REG; k++) job_data_i[k*DW +: DW] = word(seed, k);
    job_valid_i = 1;
    while (!job_ready_o && t < 50) begin tick(1); t++; end
    if (!job_ready_o) chk("job_ready_timeout", job_ready_o, 1);
    @(posedge clk_i); #1;
    job_valid_i = 0;
    job_data_i = {N_REG{32'hDEAD_BEEF}};
  endtask

  task automatic check_job(input int base, input int nacq, input int seed, input string tag);
    int e;
    chk({tag, "_ntx"}, log_n - base, nacq + N_REG + 1);
    for (int i = 0; i < nacq; i++) begin
      chk($sformatf("%s_acq%0d_add", tag, i), log_add[base+i], 32'h24);
      chk($sformatf("%s_acq%0d_wen", tag, i), log_wen[base+i], 1);
    end
    for (int k = 0; k < N_REG; k++) begin
      e = base + nacq + k;
      chk($sformatf("%s_cfg%0d_add", tag, k), log_add[e], 32'h20 + 4 * k);
      chk($sformatf("%s_cfg%0d_wen", tag, k), log_wen[e], 0);
      chk($sformatf("%s_cfg%0d_data", tag, k), log_data[e], word(seed, k));
    end
    e = base + nacq + N_REG;
    chk({tag, "_trig_add"}, log_add[e], 32'h20);
    chk({tag, "_trig_wen"}, log_wen[e], 0);
    chk({tag, "_trig_data"}, log_data[e], 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, req_o, 0);       chk({tag, "_wen"}, wen_o, 1);
    chk({tag, "_add"}, add_o, 0);       chk({tag, "_data"}, data_o, 0);
    chk({tag, "_id"}, id_o, 0);         chk({tag, "_ready"}, job_ready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);     chk({tag, "_done"}, done_o, 0);
    chk({tag, "_done_id"}, done_id_o, 0);
  endtask

  // Simple full job: bus profile given, event pulsed once WAIT is reached
  task automatic full_job(input int seed, input logic [31:0] acq, input string tag);
    int base, d0;
    acq_tab[0] = acq; acq_base = acq_cnt; base = log_n; d0 = done_cnt;
    send_job(seed);
    wait_log(base + N_REG + 2, {tag, "_log_timeout"});
    tick(5);
    chk({tag, "_busy_in_wait"}, busy_o, 1);
    chk({tag, "_no_done_before_evt"}, done_cnt - d0, 0);
    evt_cmd++;
    wait_done(d0, {tag, "_done_timeout"});
    chk({tag, "_done_id"}, last_done_id, acq[7:0]);
    tick(5);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_idle_busy"}, busy_o, 0);
    check_job(base, 1, seed, tag);
  endtask

  initial begin
    int base, d0, nclr, t;
    rst_i = 1; clear_i = 0; job_valid_i = 0; job_data_i = '0;
    evt_cmd = 0; evt_on_trig = 0; acq_base = 0;
    for (int i = 0; i < 8; i++) acq_tab[i] = 32'h0;
    set_bus(0, 0, 0, 0);
    tick(3);
    chk_reset_outs("rst");
    rst_i = 0;
    tick(1);
    chk("ready_after_rst", job_ready_o, 1);
    chk("be_all_ones", be_o, 4'hF);

    // T1: zero-wait slave, ACQUIRE returns 3
    set_bus(0, 0, 0, 0);
    full_job(1, 32'h3, "t1");

    // T2: two refused ACQUIREs, then context 0; 4 idle cycles before each retry
    set_bus(0, 0, 1, 1);
    acq_tab[0] = 32'hFFFF_FFFF; acq_tab[1] = 32'hFFFF_FFFF; acq_tab[2] = 32'h0;
    acq_base = acq_cnt; base = log_n; d0 = done_cnt;
    send_job(2);
    wait_log(base + N_REG + 4, "t2_log_timeout");
    tick(4);
    evt_cmd++;
    wait_done(d0, "t2_done_timeout");
    chk("t2_done_id", last_done_id, 0);
    check_job(base, 3, 2, "t2");
    chk("t2_gap1", log_req_cyc[base+1] - log_rsp_cyc[base] - 1, 4);
    chk("t2_gap2", log_req_cyc[base+2] - log_rsp_cyc[base+1] - 1, 4);

    // T3: random stall/latency, early event during CFG must be ignored
    set_bus(0, 5, 0, 3);
    acq_tab[0] = 32'h9C; acq_base = acq_cnt; base = log_n; d0 = done_cnt;
    send_job(3);
    wait_log(base + 6, "t3_cfg_timeout");
    evt_cmd++;
    wait_log(base + N_REG + 2, "t3_log_timeout");
    tick(8);
    chk("t3_early_evt_ignored", done_cnt - d0, 0);
    evt_cmd++;
    wait_done(d0, "t3_done_timeout");
    chk("t3_done_id", last_done_id, 8'h9C);
    check_job(base, 1, 3, "t3");

    // T4: event coincident with the TRIGGER response
    set_bus(0, 0, 1, 1);
    evt_on_trig = 1;
    acq_tab[0] = 32'h4; acq_base = acq_cnt; base = log_n; d0 = done_cnt;
    send_job(4);
    wait_log(base + N_REG + 2, "t4_log_timeout");
    wait_done(d0, "t4_done_timeout");
    evt_on_trig = 0;
    tick(8);
    chk("t4_done_once", done_cnt - d0, 1);
    chk("t4_done_id", last_done_id, 4);
    chk("t4_idle", busy_o, 0);

    // T5: clear while a CFG write is stalled waiting for gnt
    set_bus(6, 6, 1, 1);
    acq_tab[0] = 32'h11; acq_base = acq_cnt; base = log_n; d0 = done_cnt;
    send_job(5);
    wait_log(base + 4, "t5_cfg_timeout");
    t = 0;
    while (req_o && t < 50) begin tick(1); t++; end
    while (!req_o && t < 50) begin tick(1); t++; end
    chk("t5_req_seen", req_o, 1);
    nclr = log_n;
    clear_i = 1;
    tick(1);
    clear_i = 0;
    t = 0;
    while (busy_o && t < 60) begin tick(1); t++; end
    tick(10);
    chk("t5_pending_granted_only", log_n - nclr, 1);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_ready", job_ready_o, 1);
    set_bus(0, 0, 1, 1);
    full_job(6, 32'h55, "t5b");

    // T6: reset during CFG, outputs fall back immediately
    set_bus(0, 0, 1, 1);
    acq_tab[0] = 32'h22; acq_base = acq_cnt; base = log_n;
    send_job(7);
    wait_log(base + 4, "t6_cfg_timeout");
    chk("t6_busy_before", busy_o, 1);
    rst_i = 1;
    #1;
    chk_reset_outs("t6_rst");
    tick(2);
    rst_i = 0;
    tick(1);
    chk("t6_ready_after", job_ready_o, 1);
    full_job(8, 32'h77, "t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
